// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths and the register address type
package cpu_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bit per register (set by reserve, cleared by write, flush or rst); ports clk, rst, rsv_en, rsv_addr, flush, wen, waddr -> busy
module regfile_scoreboard #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int NW = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic                   flush,
  input  logic [NW-1:0]          wen,
  input  logic [NW*ADDR_W-1:0]   waddr,
  output logic [2**ADDR_W-1:0]   busy
);
  localparam int N = 2**ADDR_W;
  logic [N-1:0] clr, nxt;
  always_comb begin
    clr = '0;
    for (int p = 0; p < NW; p++)
      if (wen[p]) clr[waddr[p*ADDR_W +: ADDR_W]] = 1'b1;
    // reserve is applied last so a new producer beats both write-clear and flush
    nxt = (flush ? '0 : busy & ~clr) | (rsv_en ? {{(N-1){1'b0}}, 1'b1} << rsv_addr : '0);
    nxt[0] = 1'b0;
  end
  always_ff @(posedge clk)
    if (rst) busy <= '0;
    else busy <= nxt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file (r0 hardwired zero) with busy scoreboard; ports clk, rst, wen/waddr/wdata, raddr/rdata, rsv_en/rsv_addr, flush, busy; REGFILE_BYPASS_EN adds same-cycle write-to-read bypass
module regfile_mp #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NR = 2,
  parameter int NW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NW-1:0]        wen,
  input  logic [NW*ADDR_W-1:0] waddr,
  input  logic [NW*DATA_W-1:0] wdata,
  input  logic [NR*ADDR_W-1:0] raddr,
  output logic [NR*DATA_W-1:0] rdata,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 flush,
  output logic [2**ADDR_W-1:0] busy
);
  localparam int N = 2**ADDR_W;
  logic [DATA_W-1:0] mem [N];
  // later ports are assigned last, so the highest-index port wins a collision
  always_ff @(posedge clk)
    if (rst) for (int k = 0; k < N; k++) mem[k] <= '0;
    else for (int p = 0; p < NW; p++)
      if (wen[p] && waddr[p*ADDR_W +: ADDR_W] != '0)
        mem[waddr[p*ADDR_W +: ADDR_W]] <= wdata[p*DATA_W +: DATA_W];
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    assign a = raddr[i*ADDR_W +: ADDR_W];
    always_comb begin
      v = mem[a];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NW; p++)
        if (!rst && wen[p] && waddr[p*ADDR_W +: ADDR_W] == a) v = wdata[p*DATA_W +: DATA_W];
`endif
    end
    assign rdata[i*DATA_W +: DATA_W] = a == '0 ? '0 : v;
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NW(NW)) u_sb (
    .clk(clk), .rst(rst), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .wen(wen), .waddr(waddr), .busy(busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp (NR=2, NW=2) against a behavioural model
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] wen;
  logic [7:0] waddr;
  logic [31:0] wdata;
  logic [7:0] raddr;
  logic [31:0] rdata;
  logic rsv_en;
  logic [3:0] rsv_addr;
  logic flush;
  logic [15:0] busy;
  int checks = 0;
  int errors = 0;
  logic [15:0] m [16];
  logic [15:0] mb = '0;
  regfile_mp #(.ADDR_W(4), .DATA_W(16), .NR(2), .NW(2)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic idle();
    rst = 0; wen = 0; waddr = 0; wdata = 0; rsv_en = 0; rsv_addr = 0; flush = 0;
  endtask
  task automatic step();
    logic [15:0] nm [16];
    logic [15:0] nb;
    nm = m;
    nb = flush ? 16'h0 : mb;
    if (rst) begin
      for (int a = 0; a < 16; a++) nm[a] = 16'h0;
      nb = 16'h0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wen[p]) begin
          if (waddr[p*4 +: 4] != 0) nm[waddr[p*4 +: 4]] = wdata[p*16 +: 16];
          nb[waddr[p*4 +: 4]] = 1'b0;
        end
      if (rsv_en) nb[rsv_addr] = 1'b1;
      nb[0] = 1'b0;
    end
    @(posedge clk);
    m = nm;
    mb = nb;
    #1;
  endtask
  task automatic check_reads(string n);
    logic [3:0] a;
    logic [15:0] e;
    #1;
    for (int i = 0; i < 2; i++) begin
      a = raddr[i*4 +: 4];
      e = m[a];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < 2; p++)
        if (!rst && wen[p] && waddr[p*4 +: 4] == a) e = wdata[p*16 +: 16];
`endif
      if (a == 0) e = 16'h0;
      checks++;
      if (rdata[i*16 +: 16] !== e) begin
        errors++;
        $display("FAIL %s rd%0d addr %0d got %h exp %h", n, i, a, rdata[i*16 +: 16], e);
      end
    end
  endtask
  task automatic check_busy(string n);
    checks++;
    if (busy !== mb) begin
      errors++;
      $display("FAIL %s busy got %h exp %h", n, busy, mb);
    end
  endtask
  task automatic check_val(string n, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, got, exp);
    end
  endtask
  task automatic test_reset();
    for (int a = 0; a < 16; a++) m[a] = 16'h0;
    idle(); rst = 1; step(); idle();
    check_val("reset_busy", busy, 16'h0000);
    for (int a = 0; a < 16; a++) begin
      raddr = {4'(15 - a), 4'(a)};
      #1;
      check_val("reset_rd0", rdata[15:0], 16'h0000);
      check_val("reset_rd1", rdata[31:16], 16'h0000);
    end
  endtask
  task automatic test_basic();
    idle(); wen = 2'b01; waddr = 8'h03; wdata = 32'h0000_BEEF; step(); idle();
    raddr = {4'd0, 4'd3}; #1;
    check_val("basic_r3", rdata[15:0], 16'hBEEF);
    check_val("basic_r0", rdata[31:16], 16'h0000);
    wen = 2'b01; waddr = 8'h00; wdata = 32'h0000_1234; step(); idle();
    raddr = 8'h00; #1;
    check_val("basic_r0_write", rdata[15:0], 16'h0000);
  endtask
  task automatic test_wr_conflict();
    idle(); wen = 2'b11; waddr = 8'h55; wdata = 32'h2222_1111; step(); idle();
    raddr = 8'h05; #1;
    check_val("conflict_r5", rdata[15:0], 16'h2222);
  endtask
  task automatic test_bypass();
    logic [15:0] e;
    idle(); wen = 2'b01; waddr = 8'h07; wdata = 32'h0000_0042; step(); idle();
    wen = 2'b01; waddr = 8'h07; wdata = 32'h0000_A5A5; raddr = 8'h07; #1;
`ifdef REGFILE_BYPASS_EN
    e = 16'hA5A5;
`else
    e = 16'h0042;
`endif
    check_val("bypass_same", rdata[15:0], e);
    step(); idle(); raddr = 8'h07; #1;
    check_val("bypass_next", rdata[15:0], 16'hA5A5);
  endtask
  task automatic test_scoreboard();
    idle(); rsv_en = 1; rsv_addr = 4; step(); idle();
    check_val("sb_rsv", busy, 16'h0010);
    wen = 2'b01; waddr = 8'h04; wdata = 32'h1; step(); idle();
    check_val("sb_wr_clr", busy, 16'h0000);
    wen = 2'b10; waddr = 8'h40; wdata = 32'h2_0000; rsv_en = 1; rsv_addr = 4; step(); idle();
    check_val("sb_rsv_wr", busy, 16'h0010);
    rsv_en = 1; rsv_addr = 2; flush = 1; step(); idle();
    check_val("sb_flush_rsv", busy, 16'h0004);
    flush = 1; step(); idle();
    check_val("sb_flush", busy, 16'h0000);
    rsv_en = 1; rsv_addr = 0; step(); idle();
    check_val("sb_r0", busy, 16'h0000);
  endtask
  task automatic test_reset_mid();
    idle(); rsv_en = 1; rsv_addr = 9; step(); idle();
    check_val("mid_rsv", busy, 16'h0200);
    wen = 2'b01; waddr = 8'h09; wdata = 32'h0000_00FF; step(); idle();
    raddr = 8'h09; #1;
    check_val("mid_r9", rdata[15:0], 16'h00FF);
    rsv_en = 1; rsv_addr = 9; step(); idle();
    rst = 1; wen = 2'b11; waddr = 8'h99; wdata = 32'h5678_1234; rsv_en = 1; rsv_addr = 9;
    raddr = 8'h99;
    check_reads("mid_during_rst");
    check_val("mid_during_rst_r9", rdata[15:0], 16'h00FF);
    step(); idle(); raddr = 8'h99; #1;
    check_val("mid_after_r9", rdata[15:0], 16'h0000);
    check_val("mid_after_busy", busy, 16'h0000);
  endtask
  task automatic test_random();
    idle();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      wen = 2'($urandom);
      waddr = 8'($urandom);
      wdata = $urandom;
      raddr = 8'($urandom);
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = 4'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      check_reads("rand");
      check_busy("rand");
      step();
    end
    idle(); raddr = 8'($urandom);
    check_reads("rand_final");
    check_busy("rand_final");
  endtask
  initial begin
    idle(); raddr = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wr_conflict();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register address width; the array holds 2**ADDR_W entries.
REQ-002 SHALL have parameter DATA_W, default 16, register data width.
REQ-003 SHALL have parameter NR, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NW, default 1, number of write ports (1..2).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; one clock, synchronous active-high reset.
REQ-007 SHALL have port wen, input, NW, per-port write enable.
REQ-008 SHALL have port waddr, input, NW*ADDR_W, per-port write address; port p occupies slice p.
REQ-009 SHALL have port wdata, input, NW*DATA_W, per-port write data.
REQ-010 SHALL have port raddr, input, NR*ADDR_W, per-port read address.
REQ-011 SHALL have port rdata, output, NR*DATA_W, per-port read data.
REQ-012 SHALL have port rsv_en, input, 1, scoreboard reserve request.
REQ-013 SHALL have port rsv_addr, input, ADDR_W, register to mark busy.
REQ-014 SHALL have port flush, input, 1, clears all busy bits.
REQ-015 SHALL have port busy, output, 2**ADDR_W, registered scoreboard bit per register.

Function
REQ-016 SHALL return zero on any read of register 0 and ignore all writes to it.
REQ-017 SHALL make the read path combinational; rdata[i] equals the stored value at raddr[i] in the same cycle.
REQ-018 SHALL commit each write with wen[p]=1 at the next rising edge of clk.
REQ-019 SHALL let the highest-index port win when several write ports target the same address in one cycle.
REQ-020 SHALL set busy[rsv_addr] at the next edge when rsv_en=1 and rsv_addr!=0.
REQ-021 SHALL clear busy[a] at the next edge when any port writes address a.
REQ-022 SHALL leave busy set when reserve and write hit the same address in one cycle, because the new producer wins.
REQ-023 SHALL clear all busy bits at the next edge on flush=1; a reserve in the same cycle still sets its bit.
REQ-024 SHALL hold busy[0] at 0 permanently.
REQ-025 SHALL let rst override wen, rsv_en and flush in the same cycle.

Reset
REQ-026 SHALL clear all registers and all busy bits at the first rising edge with rst=1.
REQ-027 SHALL show rdata of 0 for every address and busy of 0 starting the cycle after that edge.
REQ-028 SHALL discard a write presented while rst=1; reset may occur mid-sequence with no residual state.

Configuration
REQ-029 SHALL compile write-to-read bypass in when macro REGFILE_BYPASS_EN is defined: rdata[i] returns the wdata of the highest-index port writing raddr[i] in the same cycle (never for register 0, never while rst=1).
REQ-030 SHALL return the previously stored value on such a same-cycle collision when REGFILE_BYPASS_EN is undefined; the new value is visible from the next cycle.

Structure
REQ-031 SHALL place in shared package cpu_pkg the default widths (ADDR_W, DATA_W) and a reg_addr_t typedef.
REQ-032 SHALL implement the busy-bit logic as one sub-module, regfile_scoreboard (reserve/write-clear/flush/reset), instantiated once.

Verification
REQ-033 SHALL cover: rst=1 one cycle, then read all 16 addresses -> every rdata=0x0000 and busy=0x0000.
REQ-034 SHALL cover: write 0xBEEF to r3, read r3 on port 0 and r0 on port 1 next cycle -> 0xBEEF and 0x0000; write 0x1234 to r0 -> r0 still 0x0000.
REQ-035 SHALL cover: NW=2, port0 writes 0x1111 and port1 writes 0x2222 to r5 in one cycle -> r5=0x2222.
REQ-036 SHALL cover: write 0xA5A5 to r7 while raddr0=7 in the same cycle -> 0xA5A5 with REGFILE_BYPASS_EN, old value without; 0xA5A5 next cycle in both builds.
REQ-037 SHALL cover: rsv r4 -> busy[4]=1; write r4 -> busy[4]=0; rsv r4 plus write r4 same cycle -> busy[4]=1; rsv r2 plus flush with r4 busy -> busy=0x0004.
REQ-038 SHALL cover: rsv r9, write r9=0x00FF, then rst=1 with wen=1 on r9 -> r9=0x0000 and busy=0x0000 after the edge.
